// File: rtl/next_value_sched_if.sv
// next_value_sched_if
// Bundles the requester handshake, the reseed port and the status outputs of
// next_value_sched. clk and rst are not part of the bundle.
//
// Handshake: a requester raises req[i] and holds it (level) until it either
// takes the value or gives up. The scheduler answers with a registered one-hot
// gnt and val_valid, and holds val_out stable while gnt is set. The granted
// requester pulses ack[i] for one cycle to take val_out. If it drops req[i]
// before acking, the grant is withdrawn without consuming the value. ack bits
// of requesters that are not granted are ignored.
//
// Signals (direction as seen by the scheduler, modport slave):
//   req[NREQ]      in   request levels
//   ack[NREQ]      in   take-value pulses
//   load           in   reseed strobe
//   load_val[W]    in   reseed value
//   step_mode      in   0 = increment, 1 = Galois LFSR
//   gnt[NREQ]      out  one-hot grant
//   val_out[W]     out  value offered to the granted requester
//   val_valid      out  high while gnt is nonzero
//   next[W]        out  current source register
//   issued_cnt[16] out  completed transfers, wraps
//   load_err       out  one-cycle pulse per rejected load
//   state_dbg      out  scheduler state (0 = IDLE, 1 = SERVE)
interface next_value_sched_if #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 64
);
   logic [NREQ-1:0]  req;
   logic [NREQ-1:0]  ack;
   logic             load;
   logic [WIDTH-1:0] load_val;
   logic             step_mode;
   logic [NREQ-1:0]  gnt;
   logic [WIDTH-1:0] val_out;
   logic             val_valid;
   logic [WIDTH-1:0] next;
   logic [15:0]      issued_cnt;
   logic             load_err;
   logic             state_dbg;

   modport master (
      output req, ack, load, load_val, step_mode,
      input  gnt, val_out, val_valid, next, issued_cnt, load_err, state_dbg
   );

   modport slave (
      input  req, ack, load, load_val, step_mode,
      output gnt, val_out, val_valid, next, issued_cnt, load_err, state_dbg
   );
endinterface

// File: rtl/next_value_sched.sv
// next_value_sched
// Shared WIDTH-bit next-value source behind a round-robin scheduler. One
// requester at a time is granted the current value; once it acks, the source
// advances (increment or Galois LFSR) and the round-robin pointer moves past
// the served requester. A load port reseeds the source while idle.
//
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  next_value_sched_if.slave (handshake, reseed, status; see interface)
module next_value_sched #(
   parameter int               NREQ  = 4,
   parameter int               WIDTH = 64,
   parameter logic [WIDTH-1:0] SEED  = 64'd1,
   parameter logic [WIDTH-1:0] TAPS  = 64'hD800000000000000
) (
   input  logic               clk,
   input  logic               rst,
   next_value_sched_if.slave  bus
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   localparam logic [0:0] S_IDLE  = 1'b0;
   localparam logic [0:0] S_SERVE = 1'b1;

   logic [0:0]       state_q;
   logic [WIDTH-1:0] next_q;
   logic [NREQ-1:0]  gnt_q;
   logic [PW-1:0]    gidx_q;   // index of the granted requester
   logic [PW-1:0]    rr_q;     // search start for the next arbitration
   logic [WIDTH-1:0] val_q;
   logic             vv_q;
   logic [15:0]      cnt_q;
   logic             lerr_q;

   logic             win_found;
   logic [PW-1:0]    win_idx;
   logic [PW-1:0]    gidx_inc;
   logic             g_ack;
   logic             g_req;

   // Value that follows v. A zero LFSR state would lock up, so it is reseeded.
   function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] v,
                                                input logic lfsr);
      logic [WIDTH-1:0] r;
      if (!lfsr)
         r = v + WIDTH'(1);
      else if (v == '0)
         r = SEED;
      else
         r = (v >> 1) ^ (v[0] ? TAPS : '0);
      return r;
   endfunction

   // Round-robin search: first set req bit at or above rr_q, wrapping.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      for (int i = 0; i < NREQ; i++) begin
         int idx;
         idx = (int'(rr_q) + i) % NREQ;
         if (!win_found && bus.req[idx]) begin
            win_found = 1'b1;
            win_idx   = PW'(idx);
         end
      end
   end

   always_comb begin
      gidx_inc = (gidx_q == PW'(NREQ - 1)) ? '0 : gidx_q + PW'(1);
      g_ack    = bus.ack[gidx_q];
      g_req    = bus.req[gidx_q];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         next_q  <= SEED;
         gnt_q   <= '0;
         gidx_q  <= '0;
         rr_q    <= '0;
         val_q   <= '0;
         vv_q    <= 1'b0;
         cnt_q   <= '0;
         lerr_q  <= 1'b0;
      end else begin
         lerr_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               // A reseed takes priority; any pending request waits a cycle.
               if (bus.load) begin
                  next_q <= bus.load_val;
               end else if (win_found) begin
                  gnt_q   <= NREQ'(1) << win_idx;
                  gidx_q  <= win_idx;
                  val_q   <= next_q;
                  vv_q    <= 1'b1;
                  state_q <= S_SERVE;
               end
            end
            S_SERVE: begin
               // The offered value must not move under the requester.
               if (bus.load)
                  lerr_q <= 1'b1;
               // ack beats a simultaneous req drop.
               if (g_ack) begin
                  gnt_q   <= '0;
                  vv_q    <= 1'b0;
                  next_q  <= advance(next_q, bus.step_mode);
                  cnt_q   <= cnt_q + 16'd1;
                  rr_q    <= gidx_inc;
                  state_q <= S_IDLE;
               end else if (!g_req) begin
                  gnt_q   <= '0;
                  vv_q    <= 1'b0;
                  rr_q    <= gidx_inc;
                  state_q <= S_IDLE;
               end
            end
            default: begin
               state_q <= S_IDLE;
               gnt_q   <= '0;
               vv_q    <= 1'b0;
            end
         endcase
      end
   end

   assign bus.gnt        = gnt_q;
   assign bus.val_out    = val_q;
   assign bus.val_valid  = vv_q;
   assign bus.next       = next_q;
   assign bus.issued_cnt = cnt_q;
   assign bus.load_err   = lerr_q;
   assign bus.state_dbg  = state_q;

endmodule

// File: tb/tb_next_value_sched.sv
// tb_next_value_sched
// Drives next_value_sched with directed and randomized transfers, aborts and
// reseeds, and compares against a transaction-level model of the scheduler.
module tb_next_value_sched;

   localparam int          NREQ  = 4;
   localparam int          WIDTH = 64;
   localparam logic [63:0] SEED  = 64'd1;
   localparam logic [63:0] TAPS  = 64'hD800000000000000;

   logic clk;
   logic rst;

   next_value_sched_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

   next_value_sched #(
      .NREQ(NREQ), .WIDTH(WIDTH), .SEED(SEED), .TAPS(TAPS)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- model / scoreboard ----------------
   int          n_checks = 0;
   int          n_errors = 0;
   logic [63:0] m_next;
   logic [15:0] m_cnt;
   int          m_rr;
   logic [WIDTH-1:0] exp_q[$];

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic int pick(input logic [NREQ-1:0] m, input int rr);
      for (int k = 0; k < NREQ; k++)
         if (m[(rr + k) % NREQ]) return (rr + k) % NREQ;
      return 0;
   endfunction

   function automatic logic [63:0] model_step(input logic [63:0] v,
                                               input bit lfsr);
      if (!lfsr) return v + 64'd1;
      if (v == 64'd0) return SEED;
      return (v >> 1) ^ (v[0] ? TAPS : 64'd0);
   endfunction

   // ---------------- driver tasks ----------------
   task automatic idle_inputs();
      bus.req = '0; bus.ack = '0; bus.load = 1'b0;
      bus.load_val = '0; bus.step_mode = 1'b0;
   endtask

   task automatic reset_dut();
      idle_inputs();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_gnt",   64'(bus.gnt), 64'd0);
      check("rst_vv",    64'(bus.val_valid), 64'd0);
      check("rst_vout",  bus.val_out, 64'd0);
      check("rst_next",  bus.next, SEED);
      check("rst_cnt",   64'(bus.issued_cnt), 64'd0);
      check("rst_lerr",  64'(bus.load_err), 64'd0);
      check("rst_state", 64'(bus.state_dbg), 64'd0);
      rst = 1'b0;
      m_next = SEED; m_cnt = '0; m_rr = 0;
      exp_q.delete();
   endtask

   task automatic load_idle(input logic [63:0] v, input logic [NREQ-1:0] mask);
      @(negedge clk);
      bus.load = 1'b1; bus.load_val = v; bus.req = mask;
      @(negedge clk);
      bus.load = 1'b0; bus.req = '0;
      check("load_nogrant", 64'(bus.gnt), 64'd0);
      check("load_next", bus.next, v);
      m_next = v;
   endtask

   // One grant followed by either an ack (do_ack) or a req drop (abort).
   task automatic transfer(input logic [NREQ-1:0] mask, input bit mode,
                           input bit do_ack, input bit serve_load);
      int w;
      logic [NREQ-1:0] oh;
      w  = pick(mask, m_rr);
      oh = NREQ'(1) << w;
      @(negedge clk);
      bus.req = mask; bus.step_mode = mode;
      exp_q.push_back(m_next);
      @(negedge clk);
      check("grant",    64'(bus.gnt), 64'(oh));
      check("vvalid",   64'(bus.val_valid), 64'd1);
      check("serve_st", 64'(bus.state_dbg), 64'd1);
      check("val_out",  bus.val_out, exp_q.pop_front());
      if (serve_load) begin
         bus.load = 1'b1; bus.load_val = {$urandom, $urandom};
      end
      if (do_ack) begin
         bus.ack = oh | NREQ'($urandom);
         if ($urandom_range(0, 1) == 1) bus.req = mask & ~oh;
         m_next = model_step(m_next, mode);
         m_cnt  = m_cnt + 16'd1;
      end else begin
         bus.req = mask & ~oh;
         bus.ack = NREQ'($urandom) & ~oh;
      end
      m_rr = (w + 1) % NREQ;
      @(negedge clk);
      bus.req = '0; bus.ack = '0; bus.load = 1'b0;
      check("done_gnt",  64'(bus.gnt), 64'd0);
      check("done_vv",   64'(bus.val_valid), 64'd0);
      check("done_next", bus.next, m_next);
      check("done_cnt",  64'(bus.issued_cnt), 64'(m_cnt));
      check("lerr",      64'(bus.load_err), 64'(serve_load));
      if (serve_load) begin
         @(negedge clk);
         check("lerr_pulse", 64'(bus.load_err), 64'd0);
      end
   endtask

   task automatic reset_mid_serve(input logic [NREQ-1:0] mask);
      @(negedge clk);
      bus.req = mask;
      @(negedge clk);
      check("pre_rst_vv", 64'(bus.val_valid), 64'd1);
      #2 rst = 1'b1;
      #1;
      check("arst_gnt",  64'(bus.gnt), 64'd0);
      check("arst_vv",   64'(bus.val_valid), 64'd0);
      check("arst_next", bus.next, SEED);
      check("arst_cnt",  64'(bus.issued_cnt), 64'd0);
      bus.req = '0;
      @(negedge clk);
      rst = 1'b0;
      m_next = SEED; m_cnt = '0; m_rr = 0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      reset_dut();

      // Basic transfer from reset.
      transfer(4'b0001, 1'b0, 1'b1, 1'b0);
      check("first_next", bus.next, 64'd2);

      // Round robin, all requesting: order 0,1,2,3,0 with values 1..5.
      reset_dut();
      for (int i = 0; i < 5; i++) transfer(4'b1111, 1'b0, 1'b1, 1'b0);

      // Increment wrap and LFSR zero state.
      load_idle(64'hFFFFFFFFFFFFFFFF, 4'b0000);
      transfer(4'b0010, 1'b0, 1'b1, 1'b0);
      check("inc_wrap", bus.next, 64'd0);
      load_idle(64'd0, 4'b0000);
      transfer(4'b0010, 1'b1, 1'b1, 1'b0);
      check("lfsr_zero", bus.next, 64'd1);

      // LFSR steps from 1.
      load_idle(64'd1, 4'b0000);
      transfer(4'b0100, 1'b1, 1'b1, 1'b0);
      check("lfsr_1", bus.next, 64'hD800000000000000);
      transfer(4'b0100, 1'b1, 1'b1, 1'b0);
      check("lfsr_2", bus.next, 64'h6C00000000000000);

      // Abort on requester 2, then 3 is next.
      reset_dut();
      transfer(4'b0100, 1'b0, 1'b0, 1'b0);
      transfer(4'b1100, 1'b0, 1'b1, 1'b0);

      // Load colliding with a request in IDLE, then load during SERVE.
      load_idle(64'h55, 4'b1011);
      transfer(4'b1011, 1'b0, 1'b1, 1'b1);
      transfer(4'b0001, 1'b1, 1'b0, 1'b1);

      // Reset in the middle of a grant.
      reset_mid_serve(4'b1000);

      // Randomized mix.
      for (int it = 0; it < 80; it++) begin
         int op;
         logic [NREQ-1:0] mask;
         op   = $urandom_range(0, 9);
         mask = NREQ'($urandom_range(1, (1 << NREQ) - 1));
         case (op)
            0: load_idle({$urandom, $urandom}, NREQ'($urandom));
            1: load_idle(($urandom_range(0, 1) == 1) ? 64'hFFFFFFFFFFFFFFFF : 64'd0,
                         NREQ'($urandom));
            2: transfer(mask, 1'($urandom), 1'b0, 1'($urandom));
            3: transfer(mask, 1'($urandom), 1'b1, 1'b1);
            default: transfer(mask, 1'($urandom), 1'b1, 1'b0);
         endcase
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
